// File: rtl/spi_serf_if.sv
// Monarch <-> serf link bundle plus the host-side register read port.
//   SS_n/SCLK/MOSI : serial inputs from the monarch (asynchronous to clk)
//   MISO           : serial data back to the monarch
//   rx_word        : last completed 16-bit frame
//   frm_done/err   : single-clk frame completion / framing error pulses
//   hst_addr       : host read address; hst_rd_data returns reg[hst_addr]
interface spi_serf_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] rx_word;
  logic        frm_done;
  logic        frm_err;
  logic [6:0]  hst_addr;
  logic [7:0]  hst_rd_data;

  modport slave (
    input  SS_n, SCLK, MOSI, hst_addr,
    output MISO, rx_word, frm_done, frm_err, hst_rd_data
  );

  modport master (
    output SS_n, SCLK, MOSI, hst_addr,
    input  MISO, rx_word, frm_done, frm_err, hst_rd_data
  );
endinterface

// File: rtl/spi_serf.sv
// SPI serf endpoint (CPOL=1, CPHA=1, MSB first) with a small 8-bit register
// file. The monarch writes or reads one register per 16-bit frame; the host
// reads the registers through a local combinational port.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : spi_serf_if.slave (serial link, frame status, host read port)
module spi_serf #(
  parameter int unsigned REG_DEPTH = 16,
  parameter logic [7:0]  ID_BYTE   = 8'h6A
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_serf_if.slave  bus
);

  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_ff, sclk_ff, mosi_ff;
  logic [15:0] tx, tx_nxt;
  logic [15:0] rx, rx_nxt;
  logic [4:0]  rise_cnt, rise_cnt_nxt;
  logic        first_fall, first_fall_nxt;
  logic [15:0] rx_word_q, rx_word_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        miso_q, miso_nxt;
  logic        wr_en;
  logic [7:0]  regs [REG_DEPTH];

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

  // Register read with out-of-range addresses returning zero.
  function automatic logic [7:0] reg_at(input logic [6:0] a);
    if (32'(a) < REG_DEPTH) return regs[a[AW-1:0]];
    return 8'h00;
  endfunction

  // Three-flop synchronisers; bit0 = ff1, bit2 = ff3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff   <= 3'b111;
      sclk_ff <= 3'b111;
      mosi_ff <= 3'b000;
    end else begin
      ss_ff   <= {ss_ff[1:0],   bus.SS_n};
      sclk_ff <= {sclk_ff[1:0], bus.SCLK};
      mosi_ff <= {mosi_ff[1:0], bus.MOSI};
    end
  end

  assign ss_fall   = ~ss_ff[1]   &  ss_ff[2];
  assign ss_rise   =  ss_ff[1]   & ~ss_ff[2];
  assign sclk_rise =  sclk_ff[1] & ~sclk_ff[2];
  assign sclk_fall = ~sclk_ff[1] &  sclk_ff[2];
  // ff3 stage holds MOSI as it was before the monarch's next update.
  assign mosi_s    = mosi_ff[2];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      rise_cnt   <= '0;
      first_fall <= 1'b0;
      rx_word_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx         <= tx_nxt;
      rx         <= rx_nxt;
      rise_cnt   <= rise_cnt_nxt;
      first_fall <= first_fall_nxt;
      rx_word_q  <= rx_word_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      miso_q     <= miso_nxt;
    end
  end

  // Next-state and datapath control; SS_n rise pre-empts any SCLK edge.
  always_comb begin
    state_nxt      = state;
    tx_nxt         = tx;
    rx_nxt         = rx;
    rise_cnt_nxt   = rise_cnt;
    first_fall_nxt = first_fall;
    rx_word_nxt    = rx_word_q;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    wr_en          = 1'b0;

    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt      = ACTIVE;
          tx_nxt         = {ID_BYTE, 8'h00};
          rise_cnt_nxt   = '0;
          first_fall_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          if (rise_cnt == 5'd16) begin
            rx_word_nxt = rx;
            done_nxt    = 1'b1;
            wr_en       = ~rx[15] && (32'(rx[14:8]) < REG_DEPTH);
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_nxt = {rx[14:0], mosi_s};
            if (rise_cnt != 5'd31) rise_cnt_nxt = rise_cnt + 5'd1;
          end
          if (sclk_fall) begin
            if (first_fall) begin
              // MISO already shows tx[15]; the first fall only arms shifting.
              first_fall_nxt = 1'b0;
            end else if (rise_cnt == 5'd8 && rx[7]) begin
              // Command byte complete on a read: present the register byte.
              tx_nxt = {reg_at(rx[6:0]), tx[7:0]};
            end else begin
              tx_nxt = {tx[14:0], 1'b0};
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    miso_nxt = (state_nxt == ACTIVE) ? tx_nxt[15] : 1'b0;
  end

  // Register file; writes commit only at a valid frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: 8'h00};
    end else if (wr_en) begin
      regs[rx[8 +: AW]] <= rx[7:0];
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.rx_word     = rx_word_q;
  assign bus.frm_done    = done_q;
  assign bus.frm_err     = err_q;
  assign bus.hst_rd_data = reg_at(bus.hst_addr);

endmodule
